pipe_seq_ctrl: RTL and testbench

Parametrised frame-pipeline sequencer for the camera/image datapath. It steps a frame through `NUM_STAGES` processing stages in fixed order, for example camera read, grayscale and filter. Each stage gets a one-hot enable and returns a done strobe. The block adds features a fixed three-stage controller lacks: continuous (looping) capture, abort, a per-stage watchdog and a frame counter. It sits between the user start/abort controls and the per-stage RWM/processing blocks.

---
 rtl/pipe_seq_pkg.sv | 14 +
 rtl/pipe_seq_watchdog.sv | 36 +++
 rtl/pipe_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the frame-pipeline sequencer.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } state_t;

  localparam int MAX_STAGES  = 8;
  localparam int ERR_STAGE_W = 3;
  localparam int IDX_W       = $clog2(MAX_STAGES);

endpackage

// File: rtl/pipe_seq_watchdog.sv
// Per-stage watchdog: counts cycles since the last clear and flags expiry
// when the count reaches a non-zero limit.
module pipe_seq_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is not masked by clear, so it beats a done arriving in the same cycle.
  assign expire = count_en && (limit != '0) && (cnt_q == limit);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Frame-pipeline sequencer: steps a frame through NUM_STAGES one-hot stages with
// looping, abort and a frame counter. The watchdog/ERR path exists only with PIPE_SEQ_WATCHDOG_EN.
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int TMO_W      = 16,
  parameter int FRAME_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   loop,
  input  logic                   abort,
  input  logic [NUM_STAGES-1:0]  stage_done,
  input  logic [TMO_W-1:0]       tmo_limit,
  output logic [NUM_STAGES-1:0]  stage_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error,
  output logic [ERR_STAGE_W-1:0] err_stage,
  output logic [FRAME_W-1:0]     frame_cnt
);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                  done_hit;
  logic                  last_stage;

`ifdef PIPE_SEQ_WATCHDOG_EN
  logic                   error_q, error_d;
  logic [ERR_STAGE_W-1:0] err_stage_q, err_stage_d;
  logic                   wd_clear;
  logic                   wd_count_en;
  logic                   wd_expire;

  // The counter restarts whenever a stage is (re)entered or the sequencer leaves RUN.
  assign wd_clear    = (state_q != RUN) || done_hit || abort;
  assign wd_count_en = (state_q == RUN);

  pipe_seq_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .limit   (tmo_limit),
    .expire  (wd_expire)
  );
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^tmo_limit;
`endif

  // Only the done strobe of the active stage counts; the others are ignored.
  always_comb begin
    done_hit = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        done_hit = stage_done[i];
      end
    end
  end

  assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef PIPE_SEQ_WATCHDOG_EN
    error_d      = error_q;
    err_stage_d  = err_stage_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
`ifdef PIPE_SEQ_WATCHDOG_EN
        end else if (wd_expire) begin
          state_d     = ERR;
          error_d     = 1'b1;
          err_stage_d = ERR_STAGE_W'(idx_q);
`endif
        end else if (done_hit) begin
          if (last_stage) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            idx_d        = '0;
            state_d      = loop ? RUN : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef PIPE_SEQ_WATCHDOG_EN
      ERR: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear on the edge that enters it.
  always_comb begin
    stage_en_d = '0;
    busy_d     = 1'b0;
    if (state_d == RUN) begin
      stage_en_d = NUM_STAGES'(1) << idx_d;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      stage_en_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef PIPE_SEQ_WATCHDOG_EN
      error_q      <= 1'b0;
      err_stage_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stage_en_q   <= stage_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef PIPE_SEQ_WATCHDOG_EN
      error_q      <= error_d;
      err_stage_q  <= err_stage_d;
`endif
    end
  end

  assign stage_en   = stage_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef PIPE_SEQ_WATCHDOG_EN
  assign error      = error_q;
  assign err_stage  = err_stage_q;
`else
  assign error      = 1'b0;
  assign err_stage  = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl (3 stages, 2-bit frame counter so wrap is visible).
// Watchdog scenarios depend on PIPE_SEQ_WATCHDOG_EN.
module tb_pipe_seq_ctrl;

  typedef struct packed {
    logic [2:0] en;
    logic       busy;
    logic       fd;
    logic       err;
    logic [2:0] es;
    logic [1:0] cnt;
  } out_t;

  typedef struct {
    out_t o;
    int   gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  stage_done = 3'b000;
  logic [15:0] tmo_limit = 16'd0;
  logic [2:0]  stage_en;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [2:0]  err_stage;
  logic [1:0]  frame_cnt;

  int   assert_count = 0;
  int   fail_count = 0;
  int   event_num = 0;
  exp_t exp_q[$];

  pipe_seq_ctrl #(
    .NUM_STAGES(3),
    .TMO_W     (16),
    .FRAME_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .loop      (loop),
    .abort     (abort),
    .stage_done(stage_done),
    .tmo_limit (tmo_limit),
    .stage_en  (stage_en),
    .busy      (busy),
    .frame_done(frame_done),
    .error     (error),
    .err_stage (err_stage),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic expectOut(input logic [2:0] en, input logic b, input logic fd,
                           input logic err, input logic [2:0] es, input logic [1:0] cnt,
                           input int gap);
    exp_t e;
    e.o   = '{en: en, busy: b, fd: fd, err: err, es: es, cnt: cnt};
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Stage advances mid-frame, then the end-of-frame pulse and its falling edge.
  task automatic expectBody(input logic [1:0] cnt_before, input logic [1:0] cnt_after,
                            input int gap1, input bit loop_out);
    expectOut(3'b010, 1'b1, 1'b0, 1'b0, 3'd0, cnt_before, gap1);
    expectOut(3'b100, 1'b1, 1'b0, 1'b0, 3'd0, cnt_before, 5);
    if (loop_out) begin
      expectOut(3'b001, 1'b1, 1'b1, 1'b0, 3'd0, cnt_after, 5);
      expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, cnt_after, 1);
    end else begin
      expectOut(3'b000, 1'b0, 1'b1, 1'b0, 3'd0, cnt_after, 5);
      expectOut(3'b000, 1'b0, 1'b0, 1'b0, 3'd0, cnt_after, 1);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int req);
    assert_count++;
    if (act !== req) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input out_t a, input int gap);
    exp_t e;
    bit   ok;
    event_num++;
    assert_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL event%0d unexpected: actual en=%b busy=%b fd=%b err=%b es=%0d cnt=%0d, required no change",
               event_num, a.en, a.busy, a.fd, a.err, a.es, a.cnt);
      return;
    end
    e  = exp_q.pop_front();
    ok = (a.en === e.o.en) && (a.busy === e.o.busy) && (a.fd === e.o.fd) &&
         (a.err === e.o.err) && (a.cnt === e.o.cnt) &&
         (!e.o.err || (a.es === e.o.es)) && ((e.gap < 0) || (gap == e.gap));
    if (!ok) begin
      fail_count++;
      $display("[TB] FAIL event%0d: actual en=%b busy=%b fd=%b err=%b es=%0d cnt=%0d gap=%0d, required en=%b busy=%b fd=%b err=%b es=%0d cnt=%0d gap=%0d",
               event_num, a.en, a.busy, a.fd, a.err, a.es, a.cnt, gap,
               e.o.en, e.o.busy, e.o.fd, e.o.err, e.o.es, e.o.cnt, e.gap);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic a, input logic [2:0] d);
    start      = s;
    loop       = l;
    abort      = a;
    stage_done = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge where stage 0 is visible.
  task automatic startFrame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the first visible cycle of stage k; done is raised in its fifth cycle.
  // Returns at the first visible cycle of whatever follows.
  task automatic doStage(input int k, input logic [2:0] stray);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      stage_done = (j == 4) ? (3'b001 << k) : ((j <= 2) ? stray : 3'b000);
    end
    @(negedge clk);
    stage_done = 3'b000;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b1;
    idle(2);
    #2 rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_stage_en"}, stage_en, 0);
    checkValue({tag, "_busy"}, busy, 0);
    checkValue({tag, "_frame_done"}, frame_done, 0);
    checkValue({tag, "_error"}, error, 0);
    checkValue({tag, "_err_stage"}, err_stage, 0);
    checkValue({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Monitor: every change of the observed outputs is one scoreboard event.
  initial begin
    out_t prev, cur;
    int   cyc, last_evt;
    prev     = '0;
    cyc      = 0;
    last_evt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev     = '0;
        last_evt = cyc;
      end else begin
        cur = '{en: stage_en, busy: busy, fd: frame_done, err: error, es: err_stage, cnt: frame_cnt};
        if (cur !== prev) begin
          checkOutput(cur, cyc - last_evt);
          prev     = cur;
          last_evt = cyc;
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL sim_timeout: actual time limit reached, required test completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    idle(2);
    #2 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    $display("[TB] single frame");
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, -1);
    expectBody(2'd0, 2'd1, 5, 1'b0);
    startFrame();
    doStage(0, 3'b000);
    doStage(1, 3'b000);
    doStage(2, 3'b000);
    idle(3);

    $display("[TB] stray done");
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, -1);
    expectBody(2'd1, 2'd2, 5, 1'b0);
    startFrame();
    doStage(0, 3'b100);
    doStage(1, 3'b000);
    doStage(2, 3'b000);
    idle(3);

    $display("[TB] abort with done");
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    expectOut(3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 5);
    expectOut(3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 3);
    startFrame();
    doStage(0, 3'b000);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    idle(2);
    abort = 1'b1;
    idle(2);
    abort = 1'b0;
    idle(3);

`ifdef PIPE_SEQ_WATCHDOG_EN
    $display("[TB] watchdog expiry at stage 1");
    tmo_limit = 16'd10;
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    expectOut(3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 5);
    expectOut(3'b000, 1'b0, 1'b0, 1'b1, 3'd1, 2'd2, 11);
    expectOut(3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    startFrame();
    doStage(0, 3'b000);
    idle(12);
    start = 1'b1;
    idle(3);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(3);

    $display("[TB] expiry and done together");
    tmo_limit = 16'd4;
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    expectOut(3'b000, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2, 5);
    expectOut(3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    startFrame();
    doStage(0, 3'b000);
    idle(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(3);
    tmo_limit = 16'd0;
`else
    $display("[TB] no watchdog, short limit ignored");
    tmo_limit = 16'd4;
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, -1);
    expectBody(2'd2, 2'd3, 5, 1'b0);
    startFrame();
    doStage(0, 3'b000);
    doStage(1, 3'b000);
    doStage(2, 3'b000);
    idle(3);
    tmo_limit = 16'd0;
`endif

    $display("[TB] loop four frames with counter wrap");
    doReset();
    @(negedge clk);
    checkValue("frame_cnt_after_reset", frame_cnt, 0);
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, -1);
    expectBody(2'd0, 2'd1, 5, 1'b1);
    expectBody(2'd1, 2'd2, 4, 1'b1);
    expectBody(2'd2, 2'd3, 4, 1'b1);
    expectBody(2'd3, 2'd0, 4, 1'b0);
    loop = 1'b1;
    startFrame();
    for (int f = 0; f < 4; f++) begin
      if (f == 3) loop = 1'b0;
      doStage(0, 3'b000);
      doStage(1, 3'b000);
      doStage(2, 3'b000);
    end
    idle(3);

    $display("[TB] async reset mid-stage");
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, -1);
    expectBody(2'd0, 2'd1, 5, 1'b0);
    expectOut(3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, -1);
    expectOut(3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 5);
    startFrame();
    doStage(0, 3'b000);
    doStage(1, 3'b000);
    doStage(2, 3'b000);
    idle(2);
    startFrame();
    doStage(0, 3'b000);
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    @(negedge clk);
    #2 rst = 1'b0;
    idle(5);

    assert_count++;
    if (exp_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: actual %0d events outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
